// File: rtl/ram_pkg.sv
// Shared definitions for the single-port RAM block and its SPI controller.
package ram_pkg;

   // Command field carried in rx_data[9:8]; the RAM block decodes these.
   localparam logic [1:0] WR_ADDR = 2'b00;
   localparam logic [1:0] WR_DATA = 2'b01;
   localparam logic [1:0] RD_ADDR = 2'b10;
   localparam logic [1:0] RD_DATA = 2'b11;

   // Default widths: 2 command bits plus an 8-bit payload, 8-bit read-back.
   localparam int DEF_WORD_W = 10;
   localparam int DEF_DATA_W = 8;

   // Controller state encoding.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } spi_state_t;

endpackage : ram_pkg

// File: rtl/spi_ram_ctrl_piso.sv
// Parallel-in serial-out byte shifter driving MISO, MSB first.
// A load presents the MSB on the next cycle; the remaining bits follow one
// per clock, after which the output returns to 0.
module spi_piso8
   import ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              load,
   input  logic [DATA_W-1:0] data,
   output logic              sout,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] shift_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              sout_reg;

   // Load, shift out remaining bits, or idle at 0; clear aborts a readout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
         sout_reg  <= 1'b0;
      end else if (clear) begin
         shift_reg <= '0;
         cnt_reg   <= '0;
         sout_reg  <= 1'b0;
      end else if (load) begin
         sout_reg  <= data[DATA_W-1];
         shift_reg <= {data[DATA_W-2:0], 1'b0};
         cnt_reg   <= CNT_W'(DATA_W - 1);
      end else if (cnt_reg != '0) begin
         sout_reg  <= shift_reg[DATA_W-1];
         shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
         cnt_reg   <= cnt_reg - 1'b1;
      end else begin
         sout_reg  <= 1'b0;
      end
   end

   assign sout = sout_reg;
   assign busy = (cnt_reg != '0);

endmodule : spi_piso8

// File: rtl/spi_ram_ctrl.sv
// SPI slave front end for the single-port RAM: turns each MOSI frame into one
// 10-bit command/data word and returns the RAM read byte on MISO.
module spi_ram_ctrl
   import ram_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [WORD_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(WORD_W);

   spi_state_t        state_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;
   logic [WORD_W-2:0] shift_reg;
   logic [WORD_W-1:0] rx_data_reg;
   logic              rx_valid_reg;
   logic              rd_addr_seen_reg;
   logic              armed_reg;

   logic              piso_load;
   logic              piso_busy;

   // A read-data word arms a single capture of the next tx_valid byte.
   assign piso_load = armed_reg && tx_valid && !SS_n && !piso_busy;

   // Frame sequencing, word deserialisation and read-address tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg        <= IDLE;
         bit_cnt_reg      <= '0;
         shift_reg        <= '0;
         rx_data_reg      <= '0;
         rx_valid_reg     <= 1'b0;
         rd_addr_seen_reg <= 1'b0;
         armed_reg        <= 1'b0;
      end else begin
         rx_valid_reg <= 1'b0;
         if (SS_n) begin
            // Deselect ends or aborts the frame; a partial word is dropped.
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            armed_reg   <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  state_reg   <= CHK_CMD;
                  bit_cnt_reg <= '0;
               end
               CHK_CMD: begin
                  if (!MOSI)
                     state_reg <= WRITE;
                  else if (rd_addr_seen_reg)
                     state_reg <= READ_DATA;
                  else
                     state_reg <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  // Counter parks at DONE_CNT so later bits in the frame are ignored.
                  if (bit_cnt_reg != DONE_CNT) begin
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     shift_reg   <= {shift_reg[WORD_W-3:0], MOSI};
                     if (bit_cnt_reg == LAST_BIT) begin
                        rx_data_reg  <= {shift_reg, MOSI};
                        rx_valid_reg <= 1'b1;
                        if (state_reg == READ_ADD)
                           rd_addr_seen_reg <= 1'b1;
                        if (state_reg == READ_DATA) begin
                           rd_addr_seen_reg <= 1'b0;
                           armed_reg        <= 1'b1;
                        end
                     end
                  end
               end
               default: state_reg <= IDLE;
            endcase
            if (piso_load)
               armed_reg <= 1'b0;
         end
      end
   end

   spi_piso8 #(
      .DATA_W (DATA_W)
   ) u_piso (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (SS_n),
      .load  (piso_load),
      .data  (tx_data),
      .sout  (MISO),
      .busy  (piso_busy)
   );

   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;

endmodule : spi_ram_ctrl

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: directed frames from the test plan
// followed by randomized frames, all checked against a frame-level model.
module tb_spi_ram_ctrl;
   import ram_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;

   int n_checks = 0;
   int n_errors = 0;

   // Frame-level model state
   bit         mdl_seen = 1'b0;
   logic [9:0] exp_rx   = '0;

   always #5 clk = ~clk;

   spi_ram_ctrl #(
      .WORD_W (10),
      .DATA_W (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One frame: SS_n low, decode bit, nbits data bits (10 = complete word,
   // then trailing junk and readout window), then SS_n high.
   // spur drives tx_valid around word completion even if no read is pending.
   // rst_k > 0 pulses rst_n asynchronously after edge rst_k.
   task automatic do_frame(input bit dec, input logic [9:0] word, input int nbits,
                           input bit spur, input int rst_k, input logic [7:0] rbyte);
      bit  full;
      bit  rd;
      bit  exp_v;
      bit  exp_m;
      int  last;
      full = (nbits >= 10);
      rd   = full && dec && mdl_seen;
      last = full ? 22 : 2 + nbits;
      $display("frame dec=%0d word=%03h bits=%0d spur=%0d rd=%0d byte=%02h rst_k=%0d",
               dec, word, nbits, spur, rd, rbyte, rst_k);
      // Idle gap, optionally with tx_valid noise while deselected
      repeat (2) begin
         @(negedge clk);
         check("idle_miso", 32'(MISO), 32'd0);
         tx_valid = spur;
         tx_data  = 8'($urandom);
      end
      @(negedge clk);
      check("idle_miso", 32'(MISO), 32'd0);
      tx_valid = 1'b0;
      SS_n     = 1'b0;
      MOSI     = 1'($urandom);
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         if (k == rst_k) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_miso", 32'(MISO), 32'd0);
            check("rst_rx_valid", 32'(rx_valid), 32'd0);
            check("rst_rx_data", 32'(rx_data), 32'd0);
            mdl_seen = 1'b0;
            exp_rx   = '0;
            SS_n     = 1'b1;
            tx_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         exp_v = full && (k == 12);
         if (exp_v) begin
            exp_rx = word;
            if (dec) mdl_seen = !mdl_seen;
         end
         exp_m = (rd && k >= 13 && k <= 20) ? rbyte[20-k] : 1'b0;
         check("rx_valid", 32'(rx_valid), 32'(exp_v));
         check("rx_data", 32'(rx_data), 32'(exp_rx));
         check("miso", 32'(MISO), 32'(exp_m));
         // Stimulus for edge k+1
         if (k == 1)
            MOSI = dec;
         else if (k >= 2 && k <= 11)
            MOSI = word[11-k];
         else
            MOSI = 1'($urandom);
         if ((rd || spur) && k >= 12 && k <= 14) begin
            tx_valid = 1'b1;
            tx_data  = (rd && k == 12) ? rbyte : 8'($urandom);
         end else begin
            tx_valid = 1'b0;
         end
         if (k == last) SS_n = 1'b1;
      end
      @(negedge clk);
      check("end_rx_valid", 32'(rx_valid), 32'd0);
      check("end_miso", 32'(MISO), 32'd0);
      check("end_rx_data", 32'(rx_data), 32'(exp_rx));
   endtask

   initial begin
      bit         d;
      logic [9:0] w;
      int         nb;
      rst_n    = 1'b0;
      SS_n     = 1'b1;
      MOSI     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      #1;
      check("reset_miso", 32'(MISO), 32'd0);
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed frames
      do_frame(1'b0, 10'h0A5, 10, 1'b0, 0, 8'h00);   // write address
      do_frame(1'b0, 10'h13C, 10, 1'b0, 0, 8'h00);   // write data
      do_frame(1'b1, 10'h2A5, 10, 1'b0, 0, 8'h00);   // read address
      do_frame(1'b1, 10'h300, 10, 1'b0, 0, 8'h3C);   // read data, readout 3C
      do_frame(1'b0, 10'h0FF,  5, 1'b0, 0, 8'h00);   // abort after 5 bits
      do_frame(1'b0, 10'h155, 10, 1'b0, 0, 8'h00);   // decodes normally afterwards
      do_frame(1'b0, 10'h0AA, 10, 1'b1, 0, 8'h00);   // spurious tx_valid
      do_frame(1'b1, 10'h281, 10, 1'b0, 0, 8'h00);   // read address
      do_frame(1'b1, 10'h3FF, 10, 1'b0, 15, 8'hFF);  // reset mid-readout
      do_frame(1'b1, 10'h2C3, 10, 1'b0, 0, 8'h00);   // must be read address
      do_frame(1'b1, 10'h3C3, 10, 1'b1, 0, 8'hA5);   // read data, tx_valid held

      // Randomized frames
      for (int i = 0; i < 40; i++) begin
         d  = 1'($urandom);
         w  = 10'($urandom);
         if (d) w[9:8] = mdl_seen ? RD_DATA : RD_ADDR;
         else   w[9]   = 1'b0;
         nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : 10;
         do_frame(d, w, nb, 1'($urandom), 0, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_spi_ram_ctrl

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- SPI slave controller that sequences the single-port RAM block: deserialises MOSI frames into 10-bit command/data words, presents them on rx_data with an rx_valid strobe, and serialises the RAM read byte back on MISO.
- Sits between the external SPI pins and the RAM's din/rx_valid/dout/tx_valid ports.
- Tracks whether a read address has been loaded so that consecutive read frames alternate between address and data.

Parameters:
WORD_W, 10, width of rx_data: 2 command bits plus 8 payload bits
DATA_W, 8, width of tx_data and of the MISO read-back byte

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
SS_n  input  1  slave select, active low; high aborts or ends a frame
MOSI  input  1  serial data in, sampled every rising clk while SS_n low
MISO  output  1  serial data out, MSB first
rx_data  output  WORD_W  deserialised word to RAM din; [9:8] = command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data)
rx_valid  output  1  one-cycle strobe, rx_data valid
tx_data  input  DATA_W  RAM read data (RAM dout)
tx_valid  input  1  RAM read data valid

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values: MISO=0, rx_data=0, rx_valid=0, state=IDLE, rd_addr_seen=0, bit counter=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- SS_n high in any state:
  - Next state is IDLE and MISO is 0.
  - A partially shifted word is discarded and rx_valid is not asserted.
  - rd_addr_seen is unchanged.
- IDLE: SS_n low -> CHK_CMD.
- CHK_CMD samples one decode bit on MOSI. This bit is not part of rx_data.
  - Decode bit 0 -> WRITE.
  - Decode bit 1 and rd_addr_seen=0 -> READ_ADD.
  - Decode bit 1 and rd_addr_seen=1 -> READ_DATA.
- WRITE, READ_ADD and READ_DATA shift the next 10 MOSI bits MSB first, one per clock, into a shift register.
  - On the 10th bit, rx_data <= completed word and rx_valid=1 for exactly one cycle. rx_data then holds until the next completed word.
  - Latency: rx_valid is high in the cycle after the edge that samples the 10th data bit, i.e. 12 edges after SS_n is first sampled low.
- READ_ADD: rd_addr_seen <= 1 on word completion.
- READ_DATA:
  - rd_addr_seen <= 0 on word completion.
  - Arm a wait for tx_valid. The first rising edge with tx_valid=1 after arming loads tx_data into the output shifter.
  - MISO drives tx_data[7] in the cycle after that edge, then bits 6..0 on successive cycles, then returns to 0.
  - tx_valid staying high is ignored after the load. tx_valid while not armed is ignored.
- After word completion, WRITE, READ_ADD and READ_DATA ignore further MOSI bits until SS_n goes high. No second rx_valid is issued in the same frame.
- The controller does not check rx_data[9:8] against the decode bit. The command field is passed to the RAM unchanged.
- Asynchronous reset mid-frame or mid-readout: immediate return to reset values. An in-flight word or byte is lost.

Decomposition:
- Shared package ram_pkg holds:
  - Command codes WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11, shared with the RAM block.
  - State encoding constants for spi_ram_ctrl.
  - WORD_W and DATA_W defaults.
- One natural sub-module, spi_piso8: an 8-bit load/shift-out register with busy flag that drives MISO. The FSM and the 10-bit deserialiser stay in spi_ram_ctrl.

Test Plan:
- Reset: assert rst_n=0 mid-frame -> MISO=0, rx_valid=0, rx_data=0 immediately. First frame after release with decode bit 1 goes to READ_ADD.
- Write address: SS_n low, decode bit 0, bits 00_1010_0101 -> single rx_valid pulse with rx_data=10'h0A5 twelve edges after SS_n low. Extra MOSI bits produce no further pulse.
- Write data: frame with decode bit 0, bits 01_0011_1100 -> rx_data=10'h13C, rx_valid one cycle.
- Read sequence:
  - Frame 1: decode bit 1, bits 10_1010_0101 -> rx_data=10'h2A5, rd_addr_seen=1.
  - Frame 2: decode bit 1, bits 11_0000_0000 -> rx_data=10'h300. The bench RAM model answers with tx_valid=1, tx_data=8'h3C. MISO shows 0,0,1,1,1,1,0,0 on consecutive cycles, then 0. rd_addr_seen=0.
- Abort: SS_n high after 5 data bits in WRITE -> no rx_valid, state IDLE next cycle. The next frame decodes normally.
- Spurious tx_valid: tx_valid=1 during WRITE or IDLE -> MISO stays 0 and no shifter load occurs.
